// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage: owns the fetch PC, issues aligned block requests and
// buffers returned instructions in a circular queue feeding up to FETCH_WIDTH decode slots.

module fetch_queue_rd_lane #(
  parameter int LANE        = 0,
  parameter int QUEUE_DEPTH = 8,
  parameter int PW          = 3,
  parameter int CW          = 4
) (
  input  logic [PW-1:0]                 head,
  input  logic [CW-1:0]                 count,
  input  logic [QUEUE_DEPTH-1:0][31:0]  q_instr,
  input  logic [QUEUE_DEPTH-1:0][31:0]  q_pc,
  output logic                          valid,
  output logic [31:0]                   instr,
  output logic [31:0]                   pc
);
  logic [PW-1:0] idx;

  assign idx   = head + PW'(LANE);
  assign valid = count > CW'(LANE);
  assign instr = q_instr[idx];
  assign pc    = q_pc[idx];
endmodule

module fetch_queue_stage #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               redirect_en,
  input  logic [31:0]                        redirect_target,
  output logic                               imem_req,
  output logic [31:0]                        imem_addr,
  input  logic [FETCH_WIDTH*32-1:0]          imem_rdata,
  input  logic                               dec_ready,
  output logic [FETCH_WIDTH-1:0]             out_valid,
  output logic [FETCH_WIDTH*32-1:0]          out_instr,
  output logic [FETCH_WIDTH*32-1:0]          out_pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count
);
  localparam int          PW       = $clog2(QUEUE_DEPTH);
  localparam int          CW       = $clog2(QUEUE_DEPTH+1);
  localparam int          OW       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [31:0] BLK_MASK = ~(32'(FETCH_WIDTH*4) - 32'd1);

  logic [31:0]                  fetch_pc;
  logic [QUEUE_DEPTH-1:0][31:0] q_instr, q_pc;
  logic [PW-1:0]                head, tail;
  logic [CW-1:0]                count;
  logic                         inflight;
  logic [OW-1:0]                inf_off, pc_off;
  logic [31:0]                  inf_addr;
  logic [31:0]                  occ;
  logic [CW-1:0]                enq_n, deq_n;

  generate
    if (FETCH_WIDTH > 1) begin : g_off
      assign pc_off = fetch_pc[OW+1:2];
    end else begin : g_no_off
      assign pc_off = '0;
    end
  endgenerate

  // Occupancy reservation counts the block already in flight so the queue can't overflow.
  assign occ       = 32'(count) + (inflight ? 32'(FETCH_WIDTH) : 32'd0);
  assign imem_addr = fetch_pc & BLK_MASK;
  assign imem_req  = reset_n & ~redirect_en & (occ <= 32'(QUEUE_DEPTH - FETCH_WIDTH));

  assign enq_n = inflight ? (CW'(FETCH_WIDTH) - CW'(inf_off)) : '0;
  assign deq_n = !dec_ready                  ? '0 :
                 (count >= CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      inf_off  <= '0;
      inf_addr <= '0;
    end else if (redirect_en) begin
      fetch_pc <= redirect_target & ~32'd3;
      head     <= tail;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      head     <= head + PW'(deq_n);
      tail     <= tail + PW'(enq_n);
      count    <= count + enq_n - deq_n;
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= imem_addr + 32'(FETCH_WIDTH*4);
        inf_addr <= imem_addr;
        inf_off  <= pc_off;
      end
    end
  end

  // Slots below the recorded offset belong to a block entered mid-way and are skipped.
  always_ff @(posedge clk) begin
    if (reset_n && !redirect_en && inflight) begin
      for (int s = 0; s < FETCH_WIDTH; s++) begin
        if (s >= int'(inf_off)) begin
          q_instr[tail + PW'(s) - PW'(inf_off)] <= imem_rdata[32*s +: 32];
          q_pc[tail + PW'(s) - PW'(inf_off)]    <= inf_addr + 32'(4*s);
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_lane
      fetch_queue_rd_lane #(
        .LANE(i), .QUEUE_DEPTH(QUEUE_DEPTH), .PW(PW), .CW(CW)
      ) u_lane (
        .head    (head),
        .count   (count),
        .q_instr (q_instr),
        .q_pc    (q_pc),
        .valid   (out_valid[i]),
        .instr   (out_instr[32*i +: 32]),
        .pc      (out_pc[32*i +: 32])
      );
    end
  endgenerate

  assign q_count = count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !redirect_en |-> (32'(count) - 32'(deq_n) + 32'(enq_n) <= 32'(QUEUE_DEPTH)));
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized bench for fetch_queue_stage against a queue-based reference model.

module tb_fetch_queue_stage;
  localparam int          FW  = 2;
  localparam int          QD  = 8;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic                          clk = 1'b0;
  logic                          reset_n, redirect_en, dec_ready;
  logic [31:0]                   redirect_target;
  logic                          imem_req;
  logic [31:0]                   imem_addr;
  logic [FW*32-1:0]              imem_rdata;
  logic [FW-1:0]                 out_valid;
  logic [FW*32-1:0]              out_instr, out_pc;
  logic [$clog2(QD+1)-1:0]       q_count;

  fetch_queue_stage #(.FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .redirect_en(redirect_en),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .dec_ready(dec_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc, m_iaddr, prev_addr;
  logic        m_inf, prev_req;
  int          m_ioff;
  int          n_cmp = 0, n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst_n, input logic redir, input logic [31:0] tgt,
                      input logic rdy);
    logic        exp_req;
    logic [31:0] exp_addr;
    int          n;
    @(negedge clk);
    reset_n = rst_n; redirect_en = redir; redirect_target = tgt; dec_ready = rdy;
    for (int s = 0; s < FW; s++)
      imem_rdata[32*s +: 32] = prev_req ? mem_word(prev_addr + 32'(4*s)) : $urandom;
    #1;
    exp_req  = rst_n && !redir && (mq.size() + (m_inf ? FW : 0) <= QD - FW);
    exp_addr = m_pc & ~32'(FW*4 - 1);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    chk("q_count", 32'(q_count), 32'(mq.size()));
    for (int s = 0; s < FW; s++) begin
      chk("out_valid", 32'(out_valid[s]), 32'(s < mq.size()));
      if (s < mq.size()) begin
        chk("out_instr", out_instr[32*s +: 32], mq[s].instr);
        chk("out_pc", out_pc[32*s +: 32], mq[s].pc);
      end
    end
    // Reference update for the coming edge.
    if (!rst_n) begin
      mq.delete(); m_pc = RPC; m_inf = 1'b0;
    end else if (redir) begin
      mq.delete(); m_pc = tgt & ~32'd3; m_inf = 1'b0;
    end else begin
      if (rdy) begin
        n = (mq.size() < FW) ? mq.size() : FW;
        repeat (n) void'(mq.pop_front());
      end
      if (m_inf)
        for (int s = m_ioff; s < FW; s++)
          mq.push_back('{mem_word(m_iaddr + 32'(4*s)), m_iaddr + 32'(4*s)});
      m_inf = exp_req;
      if (exp_req) begin
        m_iaddr = exp_addr;
        m_ioff  = int'((m_pc >> 2) & 32'(FW - 1));
        m_pc    = exp_addr + 32'(FW*4);
      end
    end
    prev_req  = exp_req;
    prev_addr = exp_addr;
  endtask

  initial begin
    reset_n = 1'b0; redirect_en = 1'b0; redirect_target = '0; dec_ready = 1'b0;
    imem_rdata = '0;
    m_pc = RPC; m_inf = 1'b0; m_iaddr = '0; m_ioff = 0; prev_req = 1'b0; prev_addr = '0;
    repeat (2) @(posedge clk);
    step(1'b0, 1'b0, 32'h0, 1'b0);             // reset state
    repeat (20) step(1'b1, 1'b0, 32'h0, 1'b1); // free run
    repeat (15) step(1'b1, 1'b0, 32'h0, 1'b0); // fill to full with decode stalled
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1); // drain and resume
    step(1'b1, 1'b1, 32'h0000_0104, 1'b1);     // unaligned redirect with a fetch in flight
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);     // redirect while decode accepts
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);             // one-cycle reset mid-stream
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (800)
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 11) == 0),
           ($urandom & 32'h0000_0FFF), ($urandom_range(0, 9) < 6));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
